regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised successor to the single-cycle register file, built for the pipelined datapath. It provides N combinational read ports, one write port and a per-register pending-write scoreboard so that decode can detect RAW hazards on in-flight results. It also offers optional write-to-read bypass and a pipeline-flush input. It sits between decode (reads, issue) and writeback (write).

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers (power of two); AW = log2(DEPTH)
- NUM_READ, 2, number of read ports
- BYPASS, 1, 1 = same-cycle writeback forwarded to read ports
- PEND_W, 2, width of per-register pending counter (max in-flight writes = 2^PEND_W−1)
- PRESET, 1, 1 = load preset values on clear

Ports:
- clock  in  1  single clock; all state updates on posedge
- clear  in  1  asynchronous, active-high reset
- read_index  in  NUM_READ*AW  packed read addresses, port k at [k*AW +: AW]
- read_data  out  NUM_READ*WIDTH  packed read data
- read_pending  out  NUM_READ  1 = addressed register has an outstanding write
- write  in  1  writeback strobe
- write_index  in  AW  writeback address
- write_data  in  WIDTH  writeback data
- issue  in  1  decode issues an instruction that will write issue_index
- issue_index  in  AW  destination of issued instruction
- issue_ready  out  1  issue would be accepted this cycle
- flush  in  1  discard all in-flight writes (clear scoreboard)
- pending_any  out  1  OR of all pending counters non-zero

## Operation
- Register 0: reads return 0, read_pending 0; writes and issues to index 0 are ignored and do not touch state.
- Clear (async): all registers 0 and all counters 0. If PRESET=1, R1=3, R2=5, R10=32'h10010000 (truncated to WIDTH).
- Write: at posedge with write=1, content[write_index] <= write_data. Counter for write_index decrements; it saturates at 0, so an untracked write is legal.
- Issue: at posedge with issue=1 and issue_ready=1, counter for issue_index increments. An issue while not ready is dropped with no state change.
- Issue and write to the same index in one cycle: counter unchanged.
- issue_ready = 0 only when counter[issue_index] == max and no same-cycle write to that index. Index 0 is always ready.
- Flush: at posedge all counters become 0, overriding same-cycle issue/write counter effects. The write data is still stored.
- Reads are combinational from content.
  - BYPASS=1, write=1 and read_index==write_index≠0: read_data = write_data, and read_pending reflects the counter after this decrement.
  - BYPASS=0: read returns stored content and the raw counter != 0.
- No errors, no stalls generated internally; decode consumes read_pending/issue_ready.

## Timing
- Read latency 0 cycles (combinational). Write visible to unbypassed reads the cycle after the strobe.
- Scoreboard update latency 1 cycle. issue_ready and pending_any are combinational from current state and inputs.
- Reset values: read_data = content (0 / presets), read_pending 0, issue_ready 1, pending_any 0.
- Clear asserted mid-operation discards any in-flight issue/write that cycle. Deassertion is synchronised externally.
- Counter wrap-around is impossible: increment is gated by issue_ready, and decrement saturates.

## Structure
- Package regfile_pkg: preset indices/values, the AW helper function, and the default PEND_W.
- One sub-module, pending_counter: a PEND_W-bit up/down counter with saturation, flush and ready output. It is instantiated DEPTH−1 times via generate.
- Read ports are generated over NUM_READ with the bypass mux inline.

## Test plan
- Clear with PRESET=1 -> R1=3, R2=5, R10=0x10010000, R7=0, all read_pending 0, issue_ready 1.
- Write R5=0xDEADBEEF while port0 reads R5 -> BYPASS=1: 0xDEADBEEF same cycle; BYPASS=0: old value, then 0xDEADBEEF next cycle.
- Issue R4 three times (PEND_W=2) -> read_pending 1, issue_ready 0 for R4; 4th issue dropped; three writes to R4 -> counter 0, read_pending 0.
- Issue and write R6 together with counter=1 -> counter stays 1; write R6 with counter 0 -> data stored, counter stays 0.
- Issue R8, R9 then flush concurrent with issue R3 -> all counters 0, pending_any 0.
- Write 0x1234 and issue to R0 -> read R0 = 0, read_pending 0; assert clear mid-stream -> immediate return to reset values.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: preset map, address-width
// helper and default pending-counter width.
package regfile_pkg;

  localparam int DEF_PEND_W = 2;

  localparam int R1_IDX  = 1;
  localparam int R2_IDX  = 2;
  localparam int R10_IDX = 10;

  localparam logic [31:0] R1_VAL  = 32'd3;
  localparam logic [31:0] R2_VAL  = 32'd5;
  localparam logic [31:0] R10_VAL = 32'h1001_0000;

  // Address bits needed for a register file of `depth` entries (minimum 1).
  function automatic int addr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic [31:0] preset_value(input int idx);
    case (idx)
      R1_IDX:  return R1_VAL;
      R2_IDX:  return R2_VAL;
      R10_IDX: return R10_VAL;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/pending_counter.sv
// Per-register in-flight write counter: saturating up/down with flush and an
// issue-ready indication that accounts for a same-cycle retiring write.
module pending_counter
  import regfile_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic clock,
  input  logic clear,
  input  logic inc_i,
  input  logic dec_i,
  input  logic flush_i,
  output logic busy_o,
  output logic busy_after_dec_o,
  output logic ready_o
);

  localparam logic [PEND_W-1:0] MAX_COUNT = '1;

  logic [PEND_W-1:0] count_q, count_d;
  logic              inc_ok;

  assign ready_o          = (count_q != MAX_COUNT) || dec_i;
  assign inc_ok           = inc_i && ready_o;
  assign busy_o           = (count_q != '0);
  assign busy_after_dec_o = dec_i ? (count_q > PEND_W'(1)) : busy_o;

  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (inc_ok && !dec_i) begin
      count_d = count_q + PEND_W'(1);
    end else if (dec_i && !inc_ok && (count_q != '0)) begin
      count_d = count_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    // NOTE: non-blocking assignments in clocked blocks keep register updates order-independent.
    if (clear) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with N combinational read ports, one write port, optional
// write-to-read bypass and a per-register pending-write scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  parameter int PEND_W   = DEF_PEND_W,
  parameter int PRESET   = 1,
  parameter int AW       = addr_width(DEPTH)
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [NUM_READ*AW-1:0]    read_index,
  output logic [NUM_READ*WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]       read_pending,
  input  logic                      write,
  input  logic [AW-1:0]             write_index,
  input  logic [WIDTH-1:0]          write_data,
  input  logic                      issue,
  input  logic [AW-1:0]             issue_index,
  output logic                      issue_ready,
  input  logic                      flush,
  output logic                      pending_any
);

  logic [WIDTH-1:0] content_q [DEPTH];
  logic [DEPTH-1:0] busy_w, busy_after_w, ready_w;

  always_ff @(posedge clock or posedge clear) begin
    // NOTE: the storage array is reset explicitly because clear must restore zeros/presets.
    if (clear) begin
      for (int i = 0; i < DEPTH; i++)
        content_q[i] <= (PRESET != 0) ? WIDTH'(preset_value(i)) : '0;
    end else if (write && (write_index != '0)) begin
      content_q[write_index] <= write_data;
    end
  end

  // Register 0 carries no counter: never pending, always ready.
  assign busy_w[0]       = 1'b0;
  assign busy_after_w[0] = 1'b0;
  assign ready_w[0]      = 1'b1;

  for (genvar i = 1; i < DEPTH; i++) begin : g_cnt
    pending_counter #(.PEND_W(PEND_W)) u_cnt (
      .clock            (clock),
      .clear            (clear),
      .inc_i            (issue && (issue_index == AW'(i))),
      .dec_i            (write && (write_index == AW'(i))),
      .flush_i          (flush),
      .busy_o           (busy_w[i]),
      .busy_after_dec_o (busy_after_w[i]),
      .ready_o          (ready_w[i])
    );
  end

  assign issue_ready = ready_w[issue_index];
  assign pending_any = |busy_w;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] idx;
    logic          hit;

    assign idx = read_index[k*AW +: AW];
    assign hit = (BYPASS != 0) && write && (write_index == idx);
    assign read_data[k*WIDTH +: WIDTH] = (idx == '0) ? '0 :
                                         hit         ? write_data : content_q[idx];
    assign read_pending[k] = hit ? busy_after_w[idx] : busy_w[idx];
  end

endmodule
